// File: rtl/riscv_pkg.sv
// RV32I encoding constants and the field-format enum shared by the encoder and decoder.
package riscv_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FmtR      = 3'd0,
        FmtI      = 3'd1,
        FmtIShift = 3'd2,
        FmtS      = 3'd3,
        FmtB      = 3'd4,
        FmtU      = 3'd5,
        FmtJ      = 3'd6,
        FmtIll    = 3'd7
    } fmt_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: fields + immediate in, 32-bit word and an immediate-legality flag out.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    fmt_t fmt;
    logic fits12;
    logic fits13;
    logic fits21;

    assign fmt = fmt_t'(fmt_i);

    // Signed range checks: every bit above the field's sign bit must equal it.
    assign fits12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign fits13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
    assign fits21 = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

    always_comb begin
        word_o    = NOP;
        illegal_o = 1'b0;
        case (fmt)
            FmtR: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FmtI: begin
                word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                illegal_o = !fits12;
            end
            FmtIShift: begin
                word_o    = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                illegal_o = |imm_i[31:5];
            end
            FmtS: begin
                word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                illegal_o = !fits12;
            end
            FmtB: begin
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
                illegal_o = imm_i[0] || !fits13;
            end
            FmtU: begin
                word_o    = {imm_i[31:12], rd_i, opcode_i};
                illegal_o = |imm_i[11:0];
            end
            FmtJ: begin
                word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                illegal_o = imm_i[0] || !fits21;
            end
            default: begin
                word_o    = NOP;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams decoded instruction fields into IMEM as packed RV32I words.
// Define ENCODER_RANGE_CHECK_EN to replace out-of-range instructions with NOP and flag them.
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_WORD   = NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] err_addr,
    output logic        ovf,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        last_q, last_d;
    logic [15:0] word_count_q, word_count_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        ovf_q, ovf_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        bad;
    logic [31:0] count_next;
    logic        unused_base;

    instr_pack u_pack (
        .fmt_i     (in_fmt),
        .opcode_i  (in_opcode),
        .rd_i      (in_rd),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .funct3_i  (in_funct3),
        .funct7_i  (in_funct7),
        .imm_i     (in_imm),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

`ifdef ENCODER_RANGE_CHECK_EN
    assign bad = pack_illegal;
`else
    logic unused_illegal;
    assign unused_illegal = pack_illegal;
    assign bad            = 1'b0;
`endif

    assign unused_base = ^base_addr[1:0];
    assign count_next  = {16'd0, word_count_q} + 32'd1;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        err_addr_d   = err_addr_q;
        ovf_d        = ovf_q;
        in_ready     = 1'b0;
        imem_we      = 1'b0;
        done         = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StAccept;
                    addr_d       = {base_addr[31:2], 2'b00};
                    word_count_d = '0;
                    err_d        = 1'b0;
                    err_addr_d   = '0;
                    ovf_d        = 1'b0;
                end
            end
            StAccept: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wdata_d = bad ? NOP_WORD : pack_word;
                    last_d  = in_last;
                    state_d = StWrite;
                    if (bad) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            err_addr_d = addr_q;
                        end
                    end
                end
            end
            StWrite: begin
                imem_we = 1'b1;
                if (imem_ready) begin
                    addr_d       = addr_q + 32'd4;
                    word_count_d = word_count_q + 16'd1;
                    if (last_q) begin
                        state_d = StDone;
                    end else if (count_next == IMEM_WORDS) begin
                        state_d = StDone;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = StAccept;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_q       <= 1'b0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            err_addr_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            err_addr_q   <= err_addr_d;
            ovf_q        <= ovf_d;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q != StIdle);
    assign err        = err_q;
    assign err_addr   = err_addr_q;
    assign ovf        = ovf_q;
    assign word_count = word_count_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit RV32I words.
- Writes the packed words sequentially into instruction memory, starting at a programmable base address.
- Used by the test/boot path to load programs into IMEM without an external assembler.
- Range-checks immediates. Out-of-range instructions are replaced with a NOP and flagged.

Parameters:
IMEM_WORDS, 1024, max words written per session; reaching it ends the session with overflow
NOP_WORD, 32'h00000013, word written in place of an illegal instruction (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load session (sampled in IDLE only)
base_addr  in  32  byte address of the first word (bits[1:0] ignored, forced 0)
in_valid  in  1  field bundle valid
in_ready  out  1  bundle accepted when in_valid&in_ready
in_fmt  in  3  0=R 1=I 2=ISHIFT 3=S 4=B 5=U 6=J (7 illegal)
in_opcode  in  7  opcode bits [6:0]
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2 / shamt source unused
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R, ISHIFT)
in_imm  in  32  signed immediate, byte offset for B/J, full value for U
in_last  in  1  final instruction of session
imem_we  out  1  write strobe
imem_addr  out  32  byte write address
imem_wdata  out  32  encoded word
imem_ready  in  1  memory accepts write when imem_we&imem_ready
busy  out  1  session active
done  out  1  one-cycle pulse at session end
err  out  1  sticky illegal-instruction flag, cleared by start
err_addr  out  32  address of the first illegal word
ovf  out  1  sticky IMEM_WORDS-limit flag, cleared by start
word_count  out  16  words written this session

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0.
- States and transitions:
  - IDLE: start=1 -> ACCEPT. On entry to ACCEPT: addr<=base_addr&~3, word_count<=0, err<=0, ovf<=0, err_addr<=0. start is ignored in every other state.
  - ACCEPT: in_ready=1. On handshake: register encoded word, addr, last flag -> WRITE.
  - WRITE: imem_we=1; imem_addr/imem_wdata held stable until imem_ready. On imem_we&imem_ready: addr+=4, word_count+=1.
    - If last, or word_count+1==IMEM_WORDS -> DONE. When the limit is hit without last, ovf<=1.
    - Otherwise -> ACCEPT.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in ACCEPT/WRITE/DONE.
- Latency: bundle accepted in cycle N; imem_we is first high in cycle N+1. Peak throughput is one word per 2 cycles.
- Packing:
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - ISHIFT: funct7|imm[4:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Legality (when checking is enabled):
  - I/S: imm in [-2048,2047]
  - ISHIFT: imm in [0,31]
  - B: imm even and in [-4096,4094]
  - J: imm even and in [-2^20, 2^20-2]
  - U: imm[11:0]==0
  - in_fmt=7: illegal
  - An illegal bundle writes NOP_WORD. err<=1; err_addr is captured only if err was 0.
- Address wrap: imem_addr increments modulo 2^32, with no special handling.
- Reset mid-session aborts immediately. No done pulse; any partial write is the memory's concern.

Optional Feature:
- Macro ENCODER_RANGE_CHECK_EN.
- Defined: legality checks as above; illegal bundles are replaced by NOP_WORD and err/err_addr are updated.
- Undefined: no checks; fields are truncated to their encoded bits; err and err_addr are tied to 0.

Decomposition:
- riscv_pkg holds:
  - opcode constants (R_TYPE, I_TYPE, STORE, LOAD, BRANCH, JALR, JAL, AUIPC, LUI)
  - the fmt_t enum
  - the NOP constant
- These constants are shared with the decoder.
- Sub-module instr_pack: purely combinational; takes fmt + fields + imm and produces word and illegal. It is reused by a future decoder-consistency checker.

Test Plan:
- start with base_addr=0x100; send I addi x1,x0,5 (last=1) -> write 0x00500093 @0x100; done pulse; word_count=1.
- Stream of R add x3,x1,x2, S sw x2,8(x1), B beq x1,x2,+8 -> writes 0x002081B3 @0x0, 0x0020A423 @0x4, 0x00208463 @0x8 in order.
- J jal x1,+16 then U lui x5,0x12345000 -> writes 0x010000EF, then 0x123452B7.
- I addi with imm=4096 at addr 0x20 -> wdata 0x00000013, err=1, err_addr=0x20. A second illegal word at 0x24 leaves err_addr=0x20. With the macro undefined -> encoded word is 0x00000093 and err=0.
- imem_ready held low for 3 cycles during WRITE -> imem_we/addr/wdata stable and in_ready=0 throughout; write completes on the first ready cycle.
- IMEM_WORDS=4, 6 bundles without last -> 4 writes, ovf=1, done pulse, return to IDLE. rst_n pulsed low mid-session -> all outputs 0 asynchronously.
